// File: rtl/ikaopm_acc_timing.sv
// ----------------------------------------------------------------------------
// ikaopm_acc_timing
// Timing sequencer for the R/L sound accumulator and output serializer.
// It divides the emulator master clock into the phi1 positive- and
// negative-edge clock enables. It also runs the 32-step master cycle counter
// and produces the registered cycle strobes. These are consumed by the
// accumulator, the PISO/SO path and the external DAC sample-and-hold.
//
// Ports:
//   i_EMUCLK          emulator master clock
//   i_MRST            synchronous reset, active-high, highest priority
//   i_STALL           emulation pause, freezes all sequencing
//   i_CYCLE_RESYNC    level request, restarts master cycle count at 0
//   o_phi1_PCEN_n     phi1 positive-edge clock enable (active-low)
//   o_phi1_NCEN_n     phi1 negative-edge clock enable (active-low)
//   o_MCYC            current master cycle number 0..31
//   o_CYCLE_12        o_MCYC == 12
//   o_CYCLE_29        o_MCYC == 29
//   o_CYCLE_00_16     o_MCYC is 0 or 16
//   o_CYCLE_06_22     o_MCYC is 6 or 22
//   o_CYCLE_01_TO_16  1 <= o_MCYC <= 16
//   o_SH1             DAC sample-hold 1, o_MCYC 24..31
//   o_SH2             DAC sample-hold 2, o_MCYC 8..15
//   o_SAMPLE_STB      one EMUCLK pulse per 32-cycle frame
// ----------------------------------------------------------------------------
module ikaopm_acc_timing #(
   parameter int DIV = 4
) (
   input  logic       i_EMUCLK,
   input  logic       i_MRST,
   input  logic       i_STALL,
   input  logic       i_CYCLE_RESYNC,
   output logic       o_phi1_PCEN_n,
   output logic       o_phi1_NCEN_n,
   output logic [4:0] o_MCYC,
   output logic       o_CYCLE_12,
   output logic       o_CYCLE_29,
   output logic       o_CYCLE_00_16,
   output logic       o_CYCLE_06_22,
   output logic       o_CYCLE_01_TO_16,
   output logic       o_SH1,
   output logic       o_SH2,
   output logic       o_SAMPLE_STB
);

   generate
      if ((DIV < 2) || ((DIV % 2) != 0)) begin : g_bad_div
         $error("ikaopm_acc_timing: DIV must be even and >= 2");
      end
   endgenerate

   localparam int PW = (DIV <= 2) ? 1 : $clog2(DIV);
   localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);
   localparam logic [PW-1:0] P_NCEN = PW'(DIV / 2);
   // Phase displayed in the period that follows the NCEN-low period; the
   // edge that loads it is the edge that ends NCEN-low.
   localparam logic [PW-1:0] P_ADV  = PW'(((DIV / 2) + 1) % DIV);

   // Decode bundle ordering: {c12, c29, c00_16, c06_22, c01_to_16, sh1, sh2}
   function automatic logic [6:0] decode_mc(input logic [4:0] mc);
      logic [6:0] d;
      d[6] = (mc == 5'd12);
      d[5] = (mc == 5'd29);
      d[4] = (mc == 5'd0) || (mc == 5'd16);
      d[3] = (mc == 5'd6) || (mc == 5'd22);
      d[2] = (mc >= 5'd1) && (mc <= 5'd16);
      d[1] = (mc >= 5'd24);
      d[0] = (mc >= 5'd8) && (mc <= 5'd15);
      return d;
   endfunction

   // cnt_r holds the prescaler phase that the next un-stalled edge will
   // display. Freezing it during a stall makes the enable sequence resume
   // with no skipped or duplicated phase.
   logic [PW-1:0] cnt_r;
   logic [PW-1:0] cnt_next_s;
   logic [4:0]    mc_r;
   logic [4:0]    mc_next_s;
   logic          armed_r;   // set once an NCEN-low period has been issued
   logic          adv_s;
   logic          stb_s;
   logic [6:0]    dec_r;
   logic          pcen_n_r;
   logic          ncen_n_r;
   logic          stb_r;

   // Next-state terms for the prescaler, the cycle counter and the frame strobe
   always_comb begin
      cnt_next_s = '0;
      mc_next_s  = '0;
      adv_s      = 1'b0;
      stb_s      = 1'b0;
      if (cnt_r == P_LAST) begin
         cnt_next_s = '0;
      end else begin
         cnt_next_s = cnt_r + PW'(1);
      end
      if (i_CYCLE_RESYNC) begin
         mc_next_s = 5'd0;
      end else begin
         mc_next_s = mc_r + 5'd1;
      end
      // armed_r keeps DIV=2 (P_ADV==0) from advancing on the first edge
      // after reset, before any NCEN-low period has been issued.
      adv_s = armed_r && (cnt_r == P_ADV);
      stb_s = (cnt_r == P_NCEN) && (mc_r == 5'd31) && !i_CYCLE_RESYNC;
   end

   // Sequencer state and registered outputs
   always_ff @(posedge i_EMUCLK) begin
      if (i_MRST) begin
         cnt_r    <= '0;
         mc_r     <= 5'd0;
         armed_r  <= 1'b0;
         dec_r    <= 7'd0;
         pcen_n_r <= 1'b1;
         ncen_n_r <= 1'b1;
         stb_r    <= 1'b0;
      end else if (i_STALL) begin
         pcen_n_r <= 1'b1;
         ncen_n_r <= 1'b1;
         stb_r    <= 1'b0;
      end else begin
         cnt_r    <= cnt_next_s;
         pcen_n_r <= (cnt_r != '0);
         ncen_n_r <= (cnt_r != P_NCEN);
         stb_r    <= stb_s;
         if (cnt_r == P_NCEN) begin
            armed_r <= 1'b1;
         end
         if (adv_s) begin
            mc_r  <= mc_next_s;
            dec_r <= decode_mc(mc_next_s);
         end
      end
   end

   assign o_phi1_PCEN_n    = pcen_n_r;
   assign o_phi1_NCEN_n    = ncen_n_r;
   assign o_MCYC           = mc_r;
   assign o_CYCLE_12       = dec_r[6];
   assign o_CYCLE_29       = dec_r[5];
   assign o_CYCLE_00_16    = dec_r[4];
   assign o_CYCLE_06_22    = dec_r[3];
   assign o_CYCLE_01_TO_16 = dec_r[2];
   assign o_SH1            = dec_r[1];
   assign o_SH2            = dec_r[0];
   assign o_SAMPLE_STB     = stb_r;

endmodule
